// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline stage with valid/ready handshake and a one-entry skid buffer.
// Resolves write-back target/data and shapes memory byte enables and store data.
module ex_mem_stage #(
  parameter int XLEN     = 32,
  parameter int RADDR_W  = 5,
  parameter int LINK_REG = 31,
  parameter int PC_STEP  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 ex_valid,
  output logic                 ex_ready,
  input  logic [XLEN-1:0]      pc_ex,
  input  logic [XLEN-1:0]      alu_out_ex,
  input  logic [XLEN-1:0]      store_data_ex,
  input  logic [RADDR_W-1:0]   rd_ex,
  input  logic [RADDR_W-1:0]   rt_ex,
  input  logic                 reg_dst,
  input  logic                 link,
  input  logic                 reg_wr_ex,
  input  logic                 mem_rd_ex,
  input  logic                 mem_wr_ex,
  input  logic                 sign_ext_ex,
  input  logic [1:0]           size_ex,
  output logic                 mem_valid,
  input  logic                 mem_ready,
  output logic [XLEN-1:0]      pc_mem,
  output logic [XLEN-1:0]      alu_out_mem,
  output logic [XLEN-1:0]      wb_data_mem,
  output logic [XLEN-1:0]      store_data_mem,
  output logic [RADDR_W-1:0]   wb_addr_mem,
  output logic                 reg_wr_mem,
  output logic                 mem_rd_mem,
  output logic                 mem_wr_mem,
  output logic                 sign_ext_mem,
  output logic                 misalign_mem,
  output logic [1:0]           size_mem,
  output logic [XLEN/8-1:0]    byte_en_mem
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    alu_out;
    logic [XLEN-1:0]    wb_data;
    logic [XLEN-1:0]    store_data;
    logic [RADDR_W-1:0] wb_addr;
    logic               reg_wr;
    logic               mem_rd;
    logic               mem_wr;
    logic               sign_ext;
    logic               misalign;
    logic [1:0]         size;
    logic [NB-1:0]      byte_en;
  } entry_t;

  entry_t           res;
  entry_t           skid;
  entry_t           out_q;
  logic             skid_valid;
  logic [1:0]       size_eff;
  logic [OFF_W-1:0] offset;
  logic [OFF_W-1:0] a_mask;
  logic [OFF_W-1:0] lane;
  logic [OFF_W-1:0] src;
  logic             mem_op;
  logic             mis;
  logic             in_xfer;
  logic             load_out;

  // An aligned access of A bytes covers the lanes sharing the offset's bits above log2(A).
  always_comb begin
    size_eff = size_ex;
    if (XLEN == 32 && size_ex == 2'b11) size_eff = 2'b10;
    a_mask = OFF_W'((4'd1 << size_eff) - 4'd1);
    offset = alu_out_ex[OFF_W-1:0];
    mem_op = mem_rd_ex | mem_wr_ex;
    mis    = mem_op & (|(offset & a_mask));
    lane   = '0;
    src    = '0;

    res          = '0;
    res.pc       = pc_ex;
    res.alu_out  = alu_out_ex;
    res.wb_addr  = link ? RADDR_W'(LINK_REG) : (reg_dst ? rd_ex : rt_ex);
    res.wb_data  = link ? pc_ex + XLEN'(PC_STEP) : alu_out_ex;
    res.reg_wr   = reg_wr_ex & (res.wb_addr != '0);
    res.mem_rd   = mem_rd_ex & ~mis;
    res.mem_wr   = mem_wr_ex & ~mis;
    res.sign_ext = sign_ext_ex;
    res.misalign = mis;
    res.size     = size_eff;
    for (int i = 0; i < NB; i++) begin
      lane = OFF_W'(i);
      src  = lane & a_mask;
      res.byte_en[i] = mem_op & ~mis & ((lane & ~a_mask) == (offset & ~a_mask));
      res.store_data[i*8 +: 8] = store_data_ex[{src, 3'b000} +: 8];
    end
  end

  assign ex_ready = ~skid_valid;
  assign in_xfer  = ex_valid & ex_ready;
  assign load_out = ~mem_valid | mem_ready;

  // The skid entry only fills while the output is stalled, so it always drains first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_q      <= '0;
      skid       <= '0;
    end else if (flush) begin
      mem_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (load_out) begin
      mem_valid  <= skid_valid | in_xfer;
      skid_valid <= 1'b0;
      if (skid_valid) out_q <= skid;
      else if (in_xfer) out_q <= res;
    end else if (in_xfer) begin
      skid       <= res;
      skid_valid <= 1'b1;
    end
  end

  assign pc_mem         = out_q.pc;
  assign alu_out_mem    = out_q.alu_out;
  assign wb_data_mem    = out_q.wb_data;
  assign store_data_mem = out_q.store_data;
  assign wb_addr_mem    = out_q.wb_addr;
  assign sign_ext_mem   = out_q.sign_ext;
  assign size_mem       = out_q.size;
  assign reg_wr_mem     = mem_valid & out_q.reg_wr;
  assign mem_rd_mem     = mem_valid & out_q.mem_rd;
  assign mem_wr_mem     = mem_valid & out_q.mem_wr;
  assign misalign_mem   = mem_valid & out_q.misalign;
  assign byte_en_mem    = mem_valid ? out_q.byte_en : '0;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: 32- and 64-bit instances share stimulus and
// are compared against a two-deep FIFO reference model plus directed vectors.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst, flush, ex_valid, mem_ready;
  logic [63:0] pc_ex, alu_out_ex, store_data_ex;
  logic [4:0]  rd_ex, rt_ex;
  logic        reg_dst, link, reg_wr_ex, mem_rd_ex, mem_wr_ex, sign_ext_ex;
  logic [1:0]  size_ex;

  logic        ex_ready32, mem_valid32, rw32, mr32, mw32, se32, mis32;
  logic [31:0] pc32, alu32, wbd32, sd32;
  logic [4:0]  wba32;
  logic [1:0]  sz32;
  logic [3:0]  be32;

  logic        ex_ready64, mem_valid64, rw64, mr64, mw64, se64, mis64;
  logic [63:0] pc64, alu64, wbd64, sd64;
  logic [4:0]  wba64;
  logic [1:0]  sz64;
  logic [7:0]  be64;

  typedef struct packed {
    logic [63:0] pc, alu, sd;
    logic [4:0]  rd, rt;
    logic        reg_dst, link, reg_wr, mem_rd, mem_wr, sign_ext;
    logic [1:0]  size;
  } in_t;

  typedef struct packed {
    logic [63:0] pc, alu, wb_data, sd;
    logic [4:0]  wb_addr;
    logic        reg_wr, mem_rd, mem_wr, sign_ext, misalign;
    logic [1:0]  size;
    logic [7:0]  byte_en;
  } res_t;

  typedef struct {
    in_t         in;
    logic        x64;
    logic [63:0] wbd, sd;
    logic [4:0]  wba;
    logic        rw, mr, mw, mis;
    logic [7:0]  be;
  } vec_t;

  in_t  cur;
  in_t  q[$];
  vec_t vecs[8];
  int   tests = 0;
  int   fails = 0;

  ex_mem_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready32),
    .pc_ex(pc_ex[31:0]), .alu_out_ex(alu_out_ex[31:0]), .store_data_ex(store_data_ex[31:0]),
    .rd_ex(rd_ex), .rt_ex(rt_ex), .reg_dst(reg_dst), .link(link), .reg_wr_ex(reg_wr_ex),
    .mem_rd_ex(mem_rd_ex), .mem_wr_ex(mem_wr_ex), .sign_ext_ex(sign_ext_ex), .size_ex(size_ex),
    .mem_valid(mem_valid32), .mem_ready(mem_ready), .pc_mem(pc32), .alu_out_mem(alu32),
    .wb_data_mem(wbd32), .store_data_mem(sd32), .wb_addr_mem(wba32), .reg_wr_mem(rw32),
    .mem_rd_mem(mr32), .mem_wr_mem(mw32), .sign_ext_mem(se32), .misalign_mem(mis32),
    .size_mem(sz32), .byte_en_mem(be32)
  );

  ex_mem_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready64),
    .pc_ex(pc_ex), .alu_out_ex(alu_out_ex), .store_data_ex(store_data_ex),
    .rd_ex(rd_ex), .rt_ex(rt_ex), .reg_dst(reg_dst), .link(link), .reg_wr_ex(reg_wr_ex),
    .mem_rd_ex(mem_rd_ex), .mem_wr_ex(mem_wr_ex), .sign_ext_ex(sign_ext_ex), .size_ex(size_ex),
    .mem_valid(mem_valid64), .mem_ready(mem_ready), .pc_mem(pc64), .alu_out_mem(alu64),
    .wb_data_mem(wbd64), .store_data_mem(sd64), .wb_addr_mem(wba64), .reg_wr_mem(rw64),
    .mem_rd_mem(mr64), .mem_wr_mem(mw64), .sign_ext_mem(se64), .misalign_mem(mis64),
    .size_mem(sz64), .byte_en_mem(be64)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic in_t mkIn(input logic [63:0] pc, alu, sd, input logic [4:0] rd, rt,
                               input logic rdst, lnk, rw, mr, mw, input logic [1:0] sz);
    in_t s;
    s = '{pc: pc, alu: alu, sd: sd, rd: rd, rt: rt, reg_dst: rdst, link: lnk, reg_wr: rw,
          mem_rd: mr, mem_wr: mw, sign_ext: 1'b0, size: sz};
    return s;
  endfunction

  // Reference behaviour computed with plain arithmetic from the access rules.
  function automatic res_t resolve(input int xl, input in_t s);
    res_t        r;
    int          nb, a, off;
    logic [1:0]  sz;
    logic [63:0] m;
    m  = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    nb = xl / 8;
    sz = s.size;
    if (xl == 32 && sz == 2'b11) sz = 2'b10;
    a   = 1 << sz;
    off = int'(s.alu[2:0]) % nb;
    r = '0;
    r.pc       = s.pc & m;
    r.alu      = s.alu & m;
    r.wb_addr  = s.link ? 5'd31 : (s.reg_dst ? s.rd : s.rt);
    r.wb_data  = s.link ? ((s.pc + 64'd4) & m) : (s.alu & m);
    r.reg_wr   = s.reg_wr && (r.wb_addr != 5'd0);
    r.misalign = (s.mem_rd || s.mem_wr) && ((off % a) != 0);
    r.mem_rd   = s.mem_rd && !r.misalign;
    r.mem_wr   = s.mem_wr && !r.misalign;
    r.sign_ext = s.sign_ext;
    r.size     = sz;
    if ((s.mem_rd || s.mem_wr) && !r.misalign) r.byte_en = 8'(((1 << a) - 1) << off);
    for (int i = 0; i < nb; i++) r.sd[i*8 +: 8] = s.sd[(i % a)*8 +: 8];
    return r;
  endfunction

  function automatic res_t act32();
    res_t r;
    r = '{pc: 64'(pc32), alu: 64'(alu32), wb_data: 64'(wbd32), sd: 64'(sd32), wb_addr: wba32,
          reg_wr: rw32, mem_rd: mr32, mem_wr: mw32, sign_ext: se32, misalign: mis32,
          size: sz32, byte_en: 8'(be32)};
    return r;
  endfunction

  function automatic res_t act64();
    res_t r;
    r = '{pc: pc64, alu: alu64, wb_data: wbd64, sd: sd64, wb_addr: wba64,
          reg_wr: rw64, mem_rd: mr64, mem_wr: mw64, sign_ext: se64, misalign: mis64,
          size: sz64, byte_en: be64};
    return r;
  endfunction

  task automatic compareInst(input string tag, input int xl, input res_t a);
    res_t e;
    if (q.size() > 0) begin
      e = resolve(xl, q[0]);
      check({tag, ".pc"}, a.pc, e.pc);
      check({tag, ".alu_out"}, a.alu, e.alu);
      check({tag, ".wb_data"}, a.wb_data, e.wb_data);
      check({tag, ".store_data"}, a.sd, e.sd);
      check({tag, ".wb_addr"}, 64'(a.wb_addr), 64'(e.wb_addr));
      check({tag, ".reg_wr"}, 64'(a.reg_wr), 64'(e.reg_wr));
      check({tag, ".mem_rd"}, 64'(a.mem_rd), 64'(e.mem_rd));
      check({tag, ".mem_wr"}, 64'(a.mem_wr), 64'(e.mem_wr));
      check({tag, ".sign_ext"}, 64'(a.sign_ext), 64'(e.sign_ext));
      check({tag, ".misalign"}, 64'(a.misalign), 64'(e.misalign));
      check({tag, ".size"}, 64'(a.size), 64'(e.size));
      check({tag, ".byte_en"}, 64'(a.byte_en), 64'(e.byte_en));
    end else begin
      check({tag, ".idle_reg_wr"}, 64'(a.reg_wr), 64'd0);
      check({tag, ".idle_mem_rd"}, 64'(a.mem_rd), 64'd0);
      check({tag, ".idle_mem_wr"}, 64'(a.mem_wr), 64'd0);
      check({tag, ".idle_misalign"}, 64'(a.misalign), 64'd0);
      check({tag, ".idle_byte_en"}, 64'(a.byte_en), 64'd0);
    end
  endtask

  task automatic checkOutput();
    check("ex_ready32", 64'(ex_ready32), 64'(q.size() < 2));
    check("ex_ready64", 64'(ex_ready64), 64'(q.size() < 2));
    check("mem_valid32", 64'(mem_valid32), 64'(q.size() > 0));
    check("mem_valid64", 64'(mem_valid64), 64'(q.size() > 0));
    compareInst("x32", 32, act32());
    compareInst("x64", 64, act64());
  endtask

  task automatic applyStimulus(input logic v, input in_t s, input logic mr, input logic fl);
    cur           = s;
    ex_valid      = v;
    mem_ready     = mr;
    flush         = fl;
    pc_ex         = s.pc;
    alu_out_ex    = s.alu;
    store_data_ex = s.sd;
    rd_ex         = s.rd;
    rt_ex         = s.rt;
    reg_dst       = s.reg_dst;
    link          = s.link;
    reg_wr_ex     = s.reg_wr;
    mem_rd_ex     = s.mem_rd;
    mem_wr_ex     = s.mem_wr;
    sign_ext_ex   = s.sign_ext;
    size_ex       = s.size;
  endtask

  // The stage behaves as a two-entry FIFO whose head is the output register.
  task automatic tick();
    bit ox, ix;
    @(posedge clk);
    if (flush) q.delete();
    else begin
      ox = (q.size() > 0) && mem_ready;
      ix = ex_valid && (q.size() < 2);
      if (ox) void'(q.pop_front());
      if (ix) q.push_back(cur);
    end
    @(negedge clk);
    checkOutput();
  endtask

  function automatic in_t aluOp(input logic [63:0] v);
    return mkIn(64'h40, v, 64'h0, 5'd4, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10);
  endfunction

  initial begin
    in_t  s;
    res_t a;
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    vecs[0] = '{mkIn(64'h1000, 64'hDEAD, 64'h0, 5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10),
                1'b0, 64'h1004, 64'h0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{mkIn(64'h0, 64'h55, 64'h0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10),
                1'b0, 64'h55, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[2] = '{mkIn(64'h0, 64'h103, 64'h11223344, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00),
                1'b0, 64'h103, 64'h44444444, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h08};
    vecs[3] = '{mkIn(64'h0, 64'h102, 64'h11223344, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01),
                1'b0, 64'h102, 64'h33443344, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0C};
    vecs[4] = '{mkIn(64'h0, 64'h102, 64'h11223344, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10),
                1'b0, 64'h102, 64'h11223344, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
    vecs[5] = '{mkIn(64'h0, 64'h104, 64'h0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b11),
                1'b0, 64'h104, 64'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 8'h0F};
    vecs[6] = '{mkIn(64'hFFFF_FFFC, 64'h0, 64'h0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10),
                1'b0, 64'h0, 64'h0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[7] = '{mkIn(64'h0, 64'h108, 64'h0102030405060708, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b11),
                1'b1, 64'h108, 64'h0102030405060708, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF};

    #1;
    check("rst_ex_ready", 64'(ex_ready32), 64'd1);
    check("rst_mem_valid", 64'(mem_valid32), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput();
    check("rst_pc32", 64'(pc32), 64'd0);
    check("rst_wbd32", 64'(wbd32), 64'd0);
    check("rst_sd64", sd64, 64'd0);
    check("rst_wba64", 64'(wba64), 64'd0);

    $display("[TB] directed vectors");
    foreach (vecs[i]) begin
      applyStimulus(1'b1, vecs[i].in, 1'b1, 1'b0);
      tick();
      a = vecs[i].x64 ? act64() : act32();
      check($sformatf("vec%0d.valid", i), 64'(vecs[i].x64 ? mem_valid64 : mem_valid32), 64'd1);
      check($sformatf("vec%0d.wb_data", i), a.wb_data, vecs[i].wbd);
      check($sformatf("vec%0d.store_data", i), a.sd, vecs[i].sd);
      check($sformatf("vec%0d.wb_addr", i), 64'(a.wb_addr), 64'(vecs[i].wba));
      check($sformatf("vec%0d.reg_wr", i), 64'(a.reg_wr), 64'(vecs[i].rw));
      check($sformatf("vec%0d.mem_rd", i), 64'(a.mem_rd), 64'(vecs[i].mr));
      check($sformatf("vec%0d.mem_wr", i), 64'(a.mem_wr), 64'(vecs[i].mw));
      check($sformatf("vec%0d.misalign", i), 64'(a.misalign), 64'(vecs[i].mis));
      check($sformatf("vec%0d.byte_en", i), 64'(a.byte_en), 64'(vecs[i].be));
      applyStimulus(1'b0, vecs[i].in, 1'b1, 1'b0);
      tick();
    end

    $display("[TB] back-to-back");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, aluOp(64'hA1 + 64'(k)), 1'b1, 1'b0);
      tick();
      check("b2b.valid", 64'(mem_valid32), 64'd1);
      check("b2b.alu", 64'(alu32), 64'hA1 + 64'(k));
    end
    applyStimulus(1'b0, aluOp(64'h0), 1'b1, 1'b0);
    tick();

    $display("[TB] stall and recovery");
    applyStimulus(1'b1, aluOp(64'hA), 1'b0, 1'b0);
    tick();
    check("stall.a_out", 64'(alu32), 64'hA);
    check("stall.ready1", 64'(ex_ready32), 64'd1);
    applyStimulus(1'b1, aluOp(64'hB), 1'b0, 1'b0);
    tick();
    check("stall.a_held", 64'(alu32), 64'hA);
    check("stall.ready0", 64'(ex_ready32), 64'd0);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, aluOp(64'hC), 1'b0, 1'b0);
      tick();
      check("stall.a_stable", 64'(alu32), 64'hA);
      check("stall.c_blocked", 64'(ex_ready32), 64'd0);
    end
    applyStimulus(1'b1, aluOp(64'hC), 1'b1, 1'b0);
    tick();
    check("stall.b_out", 64'(alu32), 64'hB);
    check("stall.ready_back", 64'(ex_ready32), 64'd1);
    applyStimulus(1'b1, aluOp(64'hC), 1'b1, 1'b0);
    tick();
    check("stall.c_out", 64'(alu32), 64'hC);
    check("stall.c_valid", 64'(mem_valid32), 64'd1);
    applyStimulus(1'b0, aluOp(64'hC), 1'b1, 1'b0);
    tick();
    check("stall.drained", 64'(mem_valid32), 64'd0);

    $display("[TB] flush");
    applyStimulus(1'b1, aluOp(64'h1A), 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, aluOp(64'h1B), 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, aluOp(64'h1D), 1'b0, 1'b1);
    tick();
    check("flush.valid", 64'(mem_valid32), 64'd0);
    check("flush.ready", 64'(ex_ready32), 64'd1);
    applyStimulus(1'b0, aluOp(64'h1D), 1'b1, 1'b0);
    tick();
    check("flush.dropped", 64'(mem_valid32), 64'd0);
    applyStimulus(1'b1, aluOp(64'h1E), 1'b1, 1'b1);
    tick();
    check("flush.priority", 64'(mem_valid64), 64'd0);

    $display("[TB] async reset mid-stall");
    applyStimulus(1'b1, aluOp(64'h2A), 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, aluOp(64'h2B), 1'b0, 1'b0);
    tick();
    #2 rst = 1'b1;
    #1;
    check("arst.valid32", 64'(mem_valid32), 64'd0);
    check("arst.valid64", 64'(mem_valid64), 64'd0);
    check("arst.ready", 64'(ex_ready32), 64'd1);
    check("arst.alu32", 64'(alu32), 64'd0);
    check("arst.pc64", pc64, 64'd0);
    check("arst.wba32", 64'(wba32), 64'd0);
    check("arst.size64", 64'(sz64), 64'd0);
    q.delete();
    #1 rst = 1'b0;
    applyStimulus(1'b0, aluOp(64'h0), 1'b1, 1'b0);
    tick();

    $display("[TB] randomized run");
    for (int n = 0; n < 400; n++) begin
      s = mkIn({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'($urandom),
               $urandom_range(0, 4) == 0, 1'($urandom), 1'($urandom), 1'($urandom),
               2'($urandom));
      if ($urandom_range(0, 7) == 0) s.rt = 5'd0;
      s.sign_ext = 1'($urandom);
      applyStimulus($urandom_range(0, 3) != 0, s, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 29) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
